// File: rtl/acc_requant.sv
// Window-differencing requantizer behind a free-running MAC: window sum, bias, rounding shift,
// saturation and a 2-entry output FIFO. Define ACC_REQUANT_RELU_EN to clamp negatives to zero.
module acc_requant #(
    parameter int unsigned ACC_BIT   = 20,
    parameter int unsigned OUT_BIT   = 8,
    parameter int unsigned CNT_BIT   = 10,
    parameter int unsigned SHIFT_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ACC_BIT-1:0]   acc_in,
    input  logic                 acc_step,
    input  logic [CNT_BIT-1:0]   kernel_len,
    input  logic [ACC_BIT-1:0]   bias,
    input  logic [SHIFT_BIT-1:0] shift,
    output logic [OUT_BIT-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf
);

    localparam logic [0:0] ACCUM   = 1'b0;
    localparam logic [0:0] CAPTURE = 1'b1;

    localparam int unsigned VW = ACC_BIT + 2;
    localparam int SAT_MAX_I = (1 << (OUT_BIT - 1)) - 1;
    localparam int SAT_MIN_I = -(1 << (OUT_BIT - 1));
    localparam logic signed [VW-1:0] SAT_MAX = VW'(SAT_MAX_I);
    localparam logic signed [VW-1:0] SAT_MIN = VW'(SAT_MIN_I);

    logic [0:0]         state_q, state_d;
    logic [CNT_BIT-1:0] cnt_q, cnt_d;
    logic [CNT_BIT-1:0] len_q, len_d;
    logic [ACC_BIT-1:0] base_q, base_d;
    logic [ACC_BIT-1:0] diff_q, diff_d;
    logic               diff_vld_q, diff_vld_d;

    logic [CNT_BIT-1:0] len_eff;
    logic [CNT_BIT-1:0] cnt_inc;
    logic [CNT_BIT-1:0] len_lim;

    assign len_eff = (kernel_len == '0) ? CNT_BIT'(1) : kernel_len;
    assign cnt_inc = cnt_q + CNT_BIT'(1);

    // Window FSM; a step seen in CAPTURE opens the next window with cnt = 1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        diff_d     = diff_q;
        diff_vld_d = 1'b0;
        len_lim    = len_q;
        unique case (state_q)
            ACCUM: begin
                if (acc_step) begin
                    if (cnt_q == '0) begin
                        len_d   = len_eff;
                        len_lim = len_eff;
                    end
                    if (cnt_inc >= len_lim) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                diff_d     = acc_in - base_q;
                base_d     = acc_in;
                diff_vld_d = 1'b1;
                state_d    = ACCUM;
                if (acc_step) begin
                    cnt_d = CNT_BIT'(1);
                    len_d = len_eff;
                end else begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            len_q      <= CNT_BIT'(1);
            base_q     <= '0;
            diff_q     <= '0;
            diff_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            base_q     <= base_d;
            diff_q     <= diff_d;
            diff_vld_q <= diff_vld_d;
        end
    end

    logic signed [VW-1:0] v_sum, v_rnd_add, v_rnd, v_shr, v_fin;
    logic [OUT_BIT-1:0]   res;

    always_comb begin
        v_sum     = {{2{diff_q[ACC_BIT-1]}}, diff_q} + {{2{bias[ACC_BIT-1]}}, bias};
        v_rnd_add = (shift != '0) ? (VW'(1) << (shift - SHIFT_BIT'(1))) : '0;
        v_rnd     = v_sum + v_rnd_add;
        v_shr     = v_rnd >>> shift;
`ifdef ACC_REQUANT_RELU_EN
        v_fin     = v_shr[VW-1] ? '0 : v_shr;
`else
        v_fin     = v_shr;
`endif
        if (v_fin > SAT_MAX) begin
            res = SAT_MAX[OUT_BIT-1:0];
        end else if (v_fin < SAT_MIN) begin
            res = SAT_MIN[OUT_BIT-1:0];
        end else begin
            res = v_fin[OUT_BIT-1:0];
        end
    end

    logic [OUT_BIT-1:0] mem_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         count_q, count_d;
    logic               ovf_q;
    logic               push, pop, full, push_ok, drop;

    assign push    = diff_vld_q;
    assign pop     = out_valid & out_ready;
    assign full    = (count_q == 2'd2);
    // When full, the popped head slot is the one written, so the write is safe.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= res;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            ovf_q   <= ovf_q | drop;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_acc_requant.sv
// Directed bench for acc_requant with a behavioural MAC and an expected-result queue.
module tb_acc_requant;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] acc_in;
    logic        acc_step;
    logic [9:0]  kernel_len;
    logic [19:0] bias;
    logic [3:0]  shift;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;

    logic [19:0] prod;
    logic [19:0] mac;
    int          checks = 0;
    int          failures = 0;
    int          exp_q[$];
    int          pops = 0;
    int          cyc = 0;
    int          last_pop = -1;
    bit          gap_en = 1'b0;
    int          pops_base;

    acc_requant dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_in     (acc_in),
        .acc_step   (acc_step),
        .kernel_len (kernel_len),
        .bias       (bias),
        .shift      (shift),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Upstream MAC: never clears, resets to 0 with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mac <= '0;
        else if (acc_step) mac <= mac + prod;
    end
    assign acc_in = mac;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int relu_or(input int v);
`ifdef ACC_REQUANT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Scoreboard: compare each transfer against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            int e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 9999;
            check("pop_data", int'($signed(out_data)), e);
            pops++;
            if (gap_en) begin
                if (last_pop >= 0) check("pop_gap", cyc - last_pop, 2);
                last_pop = cyc;
            end else begin
                last_pop = -1;
            end
        end
    end

    task automatic do_step(input int p);
        acc_step = 1'b1;
        prod = 20'(p);
        @(posedge clk);
        #1;
        acc_step = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        acc_step = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        acc_step = 1'b0;
        prod = '0;
        kernel_len = 10'd4;
        bias = '0;
        shift = 4'd2;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;

        // 10+20+30+40 >> 2 = 25, valid three cycles after the last step.
        do_step(10); do_step(20); do_step(30);
        exp_q.push_back(25);
        do_step(40);
        idle(1);
        check("lat_t2_valid", int'(out_valid), 0);
        idle(1);
        check("lat_t3_valid", int'(out_valid), 1);
        check("lat_t3_data", int'($signed(out_data)), 25);
        idle(3);

        // Round half up at shift 1: 1.5 -> 2, -1.5 -> -1.
        kernel_len = 10'd2; shift = 4'd1;
        exp_q.push_back(2);
        do_step(1); do_step(2); idle(4);
        exp_q.push_back(relu_or(-1));
        do_step(-1); do_step(-2); idle(4);

        // kernel_len 0 acts as 1.
        kernel_len = 10'd0; shift = 4'd0;
        exp_q.push_back(7);
        do_step(7); idle(4);

        // Saturation both ways.
        kernel_len = 10'd2;
        exp_q.push_back(127);
        do_step(600); do_step(400); idle(4);
        exp_q.push_back(relu_or(-128));
        do_step(-200); do_step(-100); idle(4);

        // Modular window sum across the MAC wrap, negative bias.
        do_reset();
        kernel_len = 10'd1; bias = 20'(-40); shift = 4'd0;
        exp_q.push_back(127);
        do_step(20'h7FFF0); idle(4);
        kernel_len = 10'd2;
        exp_q.push_back(8);
        do_step(20'h20); do_step(20'h10); idle(4);
        check("wrap_ovf", int'(ovf), 0);

        // Backpressure: two held, third dropped.
        bias = '0; kernel_len = 10'd1; out_ready = 1'b0;
        exp_q.push_back(5); exp_q.push_back(5);
        repeat (3) begin
            do_step(5); idle(2);
        end
        idle(2);
        check("bp_ovf", int'(ovf), 1);
        check("bp_valid", int'(out_valid), 1);
        check("bp_data", int'($signed(out_data)), 5);
        idle(3);
        check("bp_hold", int'($signed(out_data)), 5);
        out_ready = 1'b1;
        idle(4);
        check("bp_drained", exp_q.size(), 0);
        check("bp_empty", int'(out_valid), 0);
        check("bp_ovf_sticky", int'(ovf), 1);

        // Reset mid-window discards the partial sum.
        do_reset();
        kernel_len = 10'd4;
        do_step(3); do_step(3);
        do_reset();
        check("rst2_ovf", int'(ovf), 0);
        exp_q.push_back(12);
        do_step(3); do_step(3); do_step(3); do_step(3);
        idle(5);
        check("rst2_ovf_after", int'(ovf), 0);

        // Back-to-back: CAPTURE step opens the next window, so windows after the first hold 2.
        do_reset();
        kernel_len = 10'd1;
        gap_en = 1'b1;
        pops_base = pops;
        exp_q.push_back(1);
        repeat (4) exp_q.push_back(2);
        repeat (10) do_step(1);
        idle(6);
        check("b2b_pops", pops - pops_base, 5);
        check("b2b_ovf", int'(ovf), 0);
        gap_en = 1'b0;

        check("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
